div64x32_seq: RTL
=================

Name: div64x32_seq

Overview:
- Sequential radix-2 restoring divider. Divides a 64-bit unsigned dividend by a 32-bit unsigned divisor, giving a 32-bit quotient and a 32-bit remainder.
- It is the inverse datapath of the 32x32 multiplier: a mult32x32_fast product (plus a remainder) divided by one operand recovers the other.
- It uses the same start/busy handshake as the multiplier family, so the same sequencing controllers and benches can drive it.

Parameters:
- none (widths fixed: dividend 64, divisor/quotient/remainder 32)

Ports:
- clk  input  1  clock; all state changes on posedge
- reset  input  1  synchronous, active-high; sampled on posedge clk
- start  input  1  request; sampled only while idle
- dividend  input  64  unsigned dividend; sampled on the accepting edge only
- divisor  input  32  unsigned divisor; sampled on the accepting edge only
- busy  output  1  high while an operation is in progress
- quotient  output  32  result quotient; holds until the next completion
- remainder  output  32  result remainder; holds until the next completion
- div_by_zero  output  1  sticky flag for the last operation: divisor was 0
- overflow  output  1  sticky flag for the last operation: quotient would not fit in 32 bits

Behaviour:
- Reset (reset=1 at posedge, any state):
  - state=IDLE; busy=0.
  - quotient=0, remainder=0, div_by_zero=0, overflow=0.
  - Working registers cleared.
  - Reset has priority over start and aborts any operation in flight; no partial result reaches the outputs.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - busy=0.
  - start=1 at edge t0 latches dividend and divisor into working registers.
  - At the same edge, decide the path:
    - divisor==0 -> DONE with exception DZ.
    - else dividend[63:32] >= divisor -> DONE with exception OVF.
    - else -> RUN with step counter=0, R (33-bit) = {1'b0, dividend[63:32]}, Q = dividend[31:0].
  - busy becomes 1 from t0 in every case.
- RUN, one step per cycle:
  - {R,Q} shifted left 1; Q[0] takes 0.
  - If the shifted R >= {1'b0, divisor}, then R -= divisor and Q[0]=1.
  - Counter increments; after the 32nd step (counter 31) -> DONE.
- DONE (one cycle, busy still 1):
  - Normal: quotient=Q, remainder=R[31:0], div_by_zero=0, overflow=0.
  - DZ: quotient=32'hFFFF_FFFF, remainder=dividend[31:0], div_by_zero=1, overflow=0.
  - OVF: quotient=32'hFFFF_FFFF, remainder=32'h0, overflow=1, div_by_zero=0.
  - Next edge -> IDLE, busy=0.
- Latency (t0 = accepting edge):
  - Normal: busy=1 for 34 cycles (t0..t33 edges); results and flags visible after edge t33; busy falls at edge t34.
  - Exception: busy=1 for 2 cycles; results visible after edge t1; busy falls at edge t2.
  - Results are stable once busy falls.
- Handshake rules:
  - start while busy=1 is ignored. It is not queued, and the input changes are not sampled.
  - start held high continuously re-triggers on the first idle edge, i.e. back-to-back operations with one busy=0 cycle between them.
  - Input changes after t0 do not affect the operation.
- Flags are overwritten only at DONE; they persist through IDLE.
- Arithmetic invariant, normal path: dividend == quotient*divisor + remainder, with remainder < divisor.

Test Plan:
- Reset 4 cycles, then dividend=81319767993835703 (=212533089*382621682+5), divisor=382621682, start pulse 1 cycle -> busy high 34 cycles; then quotient=212533089, remainder=5, flags 0.
- dividend=1000, divisor=7 -> quotient=142, remainder=6, flags 0; busy falls 34 cycles after accept.
- dividend=64'h0000_0000_DEAD_BEEF, divisor=0 -> busy high 2 cycles; quotient=32'hFFFF_FFFF, remainder=32'hDEAD_BEEF, div_by_zero=1, overflow=0.
- dividend=64'h0000_0001_0000_0000, divisor=1 -> overflow=1, quotient=32'hFFFF_FFFF, remainder=0, busy high 2 cycles. Then dividend=64'h0000_0000_FFFF_FFFF, divisor=1 -> quotient=32'hFFFF_FFFF, remainder=0, overflow=0.
- Start 1000/7. At cycle 10 of busy, pulse start with dividend=50, divisor=5 -> ignored; result is still 142 r 6. A fresh start after busy falls -> 10 r 0.
- Start 1000/7, assert reset at cycle 15 of busy -> next cycle busy=0 and all outputs 0. A new start of 9/2 -> quotient=4, remainder=1.

Source files
------------

// File: rtl/div64x32_seq.sv
// Sequential radix-2 restoring divider: 64-bit / 32-bit unsigned, 32-bit quotient and remainder.
// Start/busy handshake; exceptions (divide-by-zero, quotient overflow) resolve in two busy cycles.
module div64x32_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [63:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        div_by_zero,
   output logic        overflow
);

   // RESULT publishes the outputs; DONE is the trailing busy cycle before returning to IDLE.
   typedef enum logic [1:0] {IDLE, RUN, RESULT, DONE} state_t;

   state_t      state_q;
   logic [32:0] rem_q;
   logic [31:0] quo_q;
   logic [31:0] dvs_q;
   logic [4:0]  cnt_q;
   logic        dz_q;
   logic        ovf_q;

   logic [32:0] shift_r;
   logic [32:0] rem_d;
   logic [31:0] quo_d;
   logic        exc_dz;
   logic        exc_ovf;

   always_comb begin
      shift_r = {rem_q[31:0], quo_q[31]};
      rem_d   = shift_r;
      quo_d   = {quo_q[30:0], 1'b0};
      if (shift_r >= {1'b0, dvs_q}) begin
         rem_d    = shift_r - {1'b0, dvs_q};
         quo_d[0] = 1'b1;
      end
   end

   assign exc_dz  = (divisor == 32'd0);
   assign exc_ovf = !exc_dz && (dividend[63:32] >= divisor);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         busy        <= 1'b0;
         quotient    <= 32'd0;
         remainder   <= 32'd0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
         rem_q       <= 33'd0;
         quo_q       <= 32'd0;
         dvs_q       <= 32'd0;
         cnt_q       <= 5'd0;
         dz_q        <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  dvs_q   <= divisor;
                  quo_q   <= dividend[31:0];
                  rem_q   <= {1'b0, dividend[63:32]};
                  cnt_q   <= 5'd0;
                  dz_q    <= exc_dz;
                  ovf_q   <= exc_ovf;
                  busy    <= 1'b1;
                  state_q <= (exc_dz || exc_ovf) ? RESULT : RUN;
               end
            end
            RUN: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_q <= RESULT;
            end
            RESULT: begin
               // quo_q still holds dividend[31:0] on the divide-by-zero path
               if (dz_q) begin
                  quotient  <= 32'hFFFF_FFFF;
                  remainder <= quo_q;
               end else if (ovf_q) begin
                  quotient  <= 32'hFFFF_FFFF;
                  remainder <= 32'd0;
               end else begin
                  quotient  <= quo_q;
                  remainder <= rem_q[31:0];
               end
               div_by_zero <= dz_q;
               overflow    <= ovf_q;
               state_q     <= DONE;
            end
            DONE: begin
               busy    <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
